ah_demux_skid: RTL and testbench

AH_DEMUX_SKID -- requirements
Module: ah_demux_skid

---
 rtl/ah_demux_skid.sv | 133 +++++++++++++
 tb/tb_ah_demux_skid.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ah_demux_skid.sv
// ah_demux_skid: one-to-NUM_EGR demultiplexer with a two-entry (main + skid)
// buffer. Ingress ready is fully registered so it never depends on egr_ready.
// Beats whose ing_sel is >= NUM_EGR are accepted and dropped.
// Optional feature macro: AH_DEMUX_DROP_CNT_EN adds a saturating 16-bit count
// of dropped beats on port drop_cnt.
module ah_demux_skid #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned NUM_EGR = 19,
  localparam int unsigned SEL_W  = (NUM_EGR > 1) ? $clog2(NUM_EGR) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           ing_data,
  input  logic [SEL_W-1:0]            ing_sel,
  input  logic                        ing_valid,
  output logic                        ing_ready,
  output logic [NUM_EGR*DATA_W-1:0]   egr_data,
  output logic [NUM_EGR-1:0]          egr_valid,
  input  logic [NUM_EGR-1:0]          egr_ready
`ifdef AH_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam logic [SEL_W:0] NumEgrW = (SEL_W + 1)'(NUM_EGR);

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_sel_q,  main_sel_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q,  skid_sel_d;
  logic              skid_valid_q, skid_valid_d;
  logic              ing_ready_q, ing_ready_d;

  logic accept;
  logic in_range;
  logic main_fire;
  logic main_free;

  assign accept    = ing_valid & ing_ready_q;
  assign in_range  = ({1'b0, ing_sel} < NumEgrW);
  assign main_fire = |(egr_valid & egr_ready);
  assign main_free = ~main_valid_q | main_fire;
  assign ing_ready = ing_ready_q;

  // Decode main entry onto the one selected channel; others stay zero.
  always_comb begin
    egr_valid = '0;
    egr_data  = '0;
    for (int unsigned i = 0; i < NUM_EGR; i++) begin
      egr_valid[i] = main_valid_q && (main_sel_q == SEL_W'(i));
      if (egr_valid[i]) begin
        egr_data[i*DATA_W +: DATA_W] = main_data_q;
      end
    end
  end

  // Next-state for main/skid entries; skid always drains into main first to keep order.
  always_comb begin
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept && in_range) begin
        main_data_d  = ing_data;
        main_sel_d   = ing_sel;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept && in_range) begin
      // ing_ready_q high implies skid is empty here.
      skid_data_d  = ing_data;
      skid_sel_d   = ing_sel;
      skid_valid_d = 1'b1;
    end
    ing_ready_d = ~skid_valid_d;
  end

  // Register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      ing_ready_q  <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      ing_ready_q  <= ing_ready_d;
    end
  end

`ifdef AH_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of accepted out-of-range beats.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ah_demux_skid.sv
// Testbench for ah_demux_skid (DATA_W=9, NUM_EGR=19): directed vector table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_ah_demux_skid;

  localparam int DW = 9;
  localparam int NE = 19;
  localparam int SW = 5;
  localparam logic [NE-1:0] ALL = '1;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     ing_data;
  logic [SW-1:0]     ing_sel;
  logic              ing_valid;
  logic              ing_ready;
  logic [NE*DW-1:0]  egr_data;
  logic [NE-1:0]     egr_valid;
  logic [NE-1:0]     egr_ready;
`ifdef AH_DEMUX_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  ah_demux_skid #(.DATA_W(DW), .NUM_EGR(NE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ing_data  (ing_data),
    .ing_sel   (ing_sel),
    .ing_valid (ing_valid),
    .ing_ready (ing_ready),
    .egr_data  (egr_data),
    .egr_valid (egr_valid),
    .egr_ready (egr_ready)
`ifdef AH_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [NE-1:0] rdy;
    logic [NE-1:0] ev;   // expected egr_valid after the edge
    logic [DW-1:0] ed;   // expected data on the valid channel
    logic          er;   // expected ing_ready after the edge
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NE*DW-1:0] exp_data(input logic [NE-1:0] v, input logic [DW-1:0] d);
    logic [NE*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NE; i++) if (v[i]) r[i*DW +: DW] = d;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic [NE-1:0] r);
    ing_valid = v;
    ing_data  = d;
    ing_sel   = s;
    egr_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [SW+DW-1:0] sb[$];
  logic [SW+DW-1:0] head;

  initial begin
    logic [NE-1:0] hol_rdy;
    logic          prev_stall;
    logic [NE-1:0] prev_valid;
    logic [NE*DW-1:0] prev_data;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    int ch;

    // vld, dat, sel, rdy, exp valid, exp data, exp ing_ready
    tbl[0]  = '{1'b1, 9'h1A5, 5'd3,  ALL,               19'h00008, 9'h1A5, 1'b1};
    tbl[1]  = '{1'b0, 9'h000, 5'd0,  ALL,               19'h00000, 9'h000, 1'b1};
    tbl[2]  = '{1'b1, 9'h0AA, 5'd5,  ~(19'd1 << 5),     19'h00020, 9'h0AA, 1'b1};
    tbl[3]  = '{1'b1, 9'h0BB, 5'd7,  ~(19'd1 << 5),     19'h00020, 9'h0AA, 1'b0};
    tbl[4]  = '{1'b1, 9'h0CC, 5'd2,  ~(19'd1 << 5),     19'h00020, 9'h0AA, 1'b0};
    tbl[5]  = '{1'b1, 9'h0CC, 5'd2,  ALL,               19'h00080, 9'h0BB, 1'b1};
    tbl[6]  = '{1'b1, 9'h0CC, 5'd2,  ALL,               19'h00004, 9'h0CC, 1'b1};
    tbl[7]  = '{1'b0, 9'h000, 5'd0,  ALL,               19'h00000, 9'h000, 1'b1};
    tbl[8]  = '{1'b1, 9'h155, 5'd19, ALL,               19'h00000, 9'h000, 1'b1};
    tbl[9]  = '{1'b1, 9'h156, 5'd31, ALL,               19'h00000, 9'h000, 1'b1};
    tbl[10] = '{1'b0, 9'h000, 5'd0,  ALL,               19'h00000, 9'h000, 1'b1};
    tbl[11] = '{1'b1, 9'h011, 5'd0,  ALL,               19'h00001, 9'h011, 1'b1};
    tbl[12] = '{1'b0, 9'h000, 5'd0,  ~19'd1,            19'h00001, 9'h011, 1'b1};
    tbl[13] = '{1'b0, 9'h000, 5'd0,  19'd1,             19'h00000, 9'h000, 1'b1};
    tbl[14] = '{1'b1, 9'h022, 5'd18, 19'd0,             19'h40000, 9'h022, 1'b1};
    tbl[15] = '{1'b1, 9'h033, 5'd0,  19'd0,             19'h40000, 9'h022, 1'b0};
    tbl[16] = '{1'b0, 9'h000, 5'd0,  19'd1,             19'h40000, 9'h022, 1'b0};
    tbl[17] = '{1'b0, 9'h000, 5'd0,  ALL,               19'h00001, 9'h033, 1'b1};
    tbl[18] = '{1'b0, 9'h000, 5'd0,  ALL,               19'h00000, 9'h000, 1'b1};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, '0, '0, ALL);
    repeat (3) step();
    chk("rst_egr_valid", 256'(egr_valid), 256'(0));
    chk("rst_egr_data",  256'(egr_data),  256'(0));
    chk("rst_ing_ready", 256'(ing_ready), 256'(0));
`ifdef AH_DEMUX_DROP_CNT_EN
    chk("rst_drop_cnt",  256'(drop_cnt),  256'(0));
`endif
    rst_n = 1'b1;
    step();
    chk("release_ing_ready", 256'(ing_ready), 256'(1));
    chk("release_egr_valid", 256'(egr_valid), 256'(0));

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].vld, tbl[i].dat, tbl[i].sel, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_valid", i), 256'(egr_valid), 256'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  256'(egr_data),  256'(exp_data(tbl[i].ev, tbl[i].ed)));
      chk($sformatf("tbl%0d_ready", i), 256'(ing_ready), 256'(tbl[i].er));
    end
`ifdef AH_DEMUX_DROP_CNT_EN
    chk("drop_cnt_two", 256'(drop_cnt), 256'(2));
`endif

    // Streaming: one beat per cycle, no bubbles
    for (int k = 0; k < 100; k++) begin
      s = SW'($urandom_range(0, NE - 1));
      d = DW'(k * 7 + 3);
      drive(1'b1, d, s, ALL);
      step();
      chk($sformatf("stream%0d_valid", k), 256'(egr_valid), 256'(19'd1 << s));
      chk($sformatf("stream%0d_data", k),  256'(egr_data),  256'(exp_data(19'd1 << s, d)));
    end
    drive(1'b0, '0, '0, ALL);
    step();
    chk("stream_end_valid", 256'(egr_valid), 256'(0));

    // Reset with main and skid both full
    drive(1'b1, 9'h0A1, 5'd4, '0);
    step();
    drive(1'b1, 9'h0B2, 5'd6, '0);
    step();
    chk("full_ing_ready", 256'(ing_ready), 256'(0));
    rst_n = 1'b0;
    drive(1'b0, '0, '0, ALL);
    step();
    chk("midrst_valid", 256'(egr_valid), 256'(0));
    chk("midrst_data",  256'(egr_data),  256'(0));
    chk("midrst_ready", 256'(ing_ready), 256'(0));
    rst_n = 1'b1;
    step();
    chk("midrel_ready", 256'(ing_ready), 256'(1));
    hol_rdy = '0;
    for (int k = 0; k < 4; k++) begin
      hol_rdy = hol_rdy | egr_valid;
      step();
    end
    chk("midrel_no_stale", 256'(hol_rdy | egr_valid), 256'(0));

    // Randomized backpressure with scoreboard
    prev_stall = 1'b0;
    prev_valid = '0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      ing_valid = ($urandom_range(0, 3) != 0);
      ing_sel   = SW'($urandom_range(0, 22));
      ing_data  = DW'($urandom);
      for (int i = 0; i < NE; i++) egr_ready[i] = ($urandom_range(0, 2) != 0);
      #3;
      if (prev_stall) begin
        chk("stall_valid", 256'(egr_valid), 256'(prev_valid));
        chk("stall_data",  256'(egr_data),  256'(prev_data));
      end
      if ((egr_valid & egr_ready) != '0) begin
        ch = -1;
        for (int i = 0; i < NE; i++) if (egr_valid[i]) ch = i;
        if (sb.size() == 0) begin
          chk("spurious_beat", 256'(1), 256'(0));
        end else begin
          head = sb.pop_front();
          chk("sb_sel",  256'(ch), 256'(head[DW +: SW]));
          chk("sb_data", 256'(egr_data[ch*DW +: DW]), 256'(head[DW-1:0]));
        end
      end
      if (ing_valid && ing_ready && (ing_sel < SW'(NE))) sb.push_back({ing_sel, ing_data});
      prev_stall = (egr_valid != '0) && ((egr_valid & egr_ready) == '0);
      prev_valid = egr_valid;
      prev_data  = egr_data;
      step();
    end
    // Drain remaining beats with all ready, bounded
    drive(1'b0, '0, '0, ALL);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      #3;
      if (egr_valid != '0) begin
        ch = -1;
        for (int i = 0; i < NE; i++) if (egr_valid[i]) ch = i;
        head = sb.pop_front();
        chk("drain_sel",  256'(ch), 256'(head[DW +: SW]));
        chk("drain_data", 256'(egr_data[ch*DW +: DW]), 256'(head[DW-1:0]));
      end
      step();
    end
    chk("sb_empty", 256'(sb.size()), 256'(0));
    step();
    chk("final_idle", 256'(egr_valid), 256'(0));

`ifdef AH_DEMUX_DROP_CNT_EN
    // Saturation: count up to FFFE, then three more drops
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 9'h000, 5'd31, ALL);
    repeat (65534) step();
    chk("drop_cnt_fffe", 256'(drop_cnt), 256'(16'hFFFE));
    repeat (3) step();
    drive(1'b0, '0, '0, ALL);
    step();
    chk("drop_cnt_sat", 256'(drop_cnt), 256'(16'hFFFF));
    chk("drop_no_valid", 256'(egr_valid), 256'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
